// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Holds the FSM state encoding, the default frame marker and address width.
package imem_loader_pkg;

  localparam int         ADDR_W_DEF = 6;
  localparam logic [7:0] SYNC_DEF   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Byte-to-word assembler: 32-bit shift register, byte index, XOR checksum.
// Ports: clk, rst (async low), clr, en, din -> nxt word, chk, last byte flag.
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] nxt,
  output logic [7:0]  chk,
  output logic        last
);

  logic [31:0] word;
  logic [1:0]  idx;

  // Big-endian: earlier bytes end up in the high lanes.
  assign nxt  = {word[23:0], din};
  assign last = en && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= '0;
      chk  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
      chk  <= '0;
    end else if (en) begin
      word <= nxt;
      idx  <= idx + 2'd1;
      chk  <= chk ^ din;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/COUNT/data/CHK frames into imem writes.
// Ports: byte stream in (valid/ready), imem write port, cpu_rst, status.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          CW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t        state;
  logic [CW-1:0] count;
  logic          acc;
  logic          sync;
  logic          bad_cnt;
  logic          asm_clr;
  logic          asm_en;
  logic [31:0]   asm_nxt;
  logic [7:0]    asm_chk;
  logic          asm_last;

  assign acc     = in_valid && in_ready;
  assign sync    = in_data == SYNC_BYTE;
  assign bad_cnt = (in_data == 8'd0) ||
                   (32'(in_data) > DEPTH);
  assign asm_clr = acc && (state == COUNT);
  assign asm_en  = acc && (state == DATA);

  byte_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (asm_clr),
    .en   (asm_en),
    .din  (in_data),
    .nxt  (asm_nxt),
    .chk  (asm_chk),
    .last (asm_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_rst      <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_we    <= 1'b0;
      in_ready <= 1'b1;
      unique case (state)
        IDLE: begin
          if (acc && sync) state <= COUNT;
        end
        COUNT: begin
          if (acc) begin
            if (bad_cnt) begin
              state    <= ERROR;
              load_err <= 1'b1;
            end else begin
              count        <= CW'(in_data);
              words_loaded <= '0;
              state        <= DATA;
            end
          end
        end
        DATA: begin
          // Write cycle: ready is low, so no byte can land here.
          if (im_we) begin
            words_loaded <= words_loaded + CW'(1);
            if (words_loaded + CW'(1) == count)
              state <= CHECK;
          end else if (asm_last) begin
            im_we    <= 1'b1;
            im_addr  <= words_loaded[ADDR_W-1:0];
            im_wdata <= asm_nxt;
            in_ready <= 1'b0;
          end
        end
        CHECK: begin
          if (acc) begin
            if (in_data == asm_chk) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_rst   <= 1'b0;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc && sync) begin
            state     <= COUNT;
            load_done <= 1'b0;
            cpu_rst   <= 1'b1;
          end
        end
        ERROR: begin
          if (acc && sync) begin
            state    <= COUNT;
            load_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, random frames,
// mid-frame reset, with a frame-level memory/status reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] dut_mem   [DEPTH];
  logic [31:0] model_mem [DEPTH];
  logic [7:0]  garbage   [3] = '{8'h00, 8'hFF, 8'h12};

  int we_cnt  = 0;
  int low_cnt = 0;
  int viol    = 0;
  int cur_lim = 0;
  bit armed   = 1'b0;
  bit prev_we = 1'b0;

  // Memory image capture and handshake/address invariants.
  always @(negedge clk) begin
    if (rst && im_we) begin
      dut_mem[im_addr] = im_wdata;
      we_cnt++;
      if (int'(im_addr) >= cur_lim || prev_we) viol++;
    end
    if (armed) begin
      if (in_ready == im_we) viol++;
      if (!in_ready) low_cnt++;
    end
    prev_we = im_we;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready 0, expected 1");
    end
  endtask

  task automatic run_frame(input int cnt, input bit flip,
                           input int garb, input bit allsync,
                           input bit fixed0, input bit gaps);
    logic [31:0] w;
    logic [7:0]  x;
    logic [7:0]  b;
    bit          ok_cnt;
    ok_cnt  = cnt >= 1 && cnt <= DEPTH;
    cur_lim = ok_cnt ? cnt : 0;
    x = 8'h00;
    for (int g = 0; g < garb; g++) send_byte(garbage[g]);
    send_byte(8'hA5);
    send_byte(8'(cnt));
    if (ok_cnt) begin
      for (int i = 0; i < cnt; i++) begin
        if (allsync) w = 32'hA5A5A5A5;
        else if (fixed0 && i == 0) w = 32'h010A4820;
        else w = $urandom;
        model_mem[i] = w;
        for (int k = 0; k < 4; k++) begin
          b = w[31-8*k -: 8];
          x = x ^ b;
          send_byte(b);
          if (gaps && $urandom_range(0, 3) == 0)
            idle($urandom_range(1, 2));
        end
      end
      send_byte(flip ? (x ^ 8'h01) : x);
    end
    idle(4);
  endtask

  task automatic check_frame(input string nm, input bit e_done,
                             input bit e_err, input int e_we,
                             input int we0, input int low0);
    int mm;
    mm = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut_mem[i] !== model_mem[i]) mm++;
    chk({nm, "_done"}, 32'(load_done), 32'(e_done));
    chk({nm, "_err"}, 32'(load_err), 32'(e_err));
    chk({nm, "_cpu_rst"}, 32'(cpu_rst), 32'(!e_done));
    chk({nm, "_we_pulses"}, 32'(we_cnt - we0), 32'(e_we));
    chk({nm, "_ready_low"}, 32'(low_cnt - low0), 32'(e_we));
    chk({nm, "_mem_mismatch"}, 32'(mm), 32'd0);
    if (e_we > 0)
      chk({nm, "_words"}, 32'(words_loaded), 32'(e_we));
  endtask

  typedef struct {
    int cnt;
    bit flip;
    int garb;
    bit allsync;
    bit fixed0;
    bit e_done;
    bit e_err;
    int e_we;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int  we0, low0, c, pick;
    bit  fl, ok_cnt;
    logic [31:0] w0, w1;

    for (int i = 0; i < DEPTH; i++) begin
      dut_mem[i]   = 32'h0;
      model_mem[i] = 32'h0;
    end

    tbl[0] = '{7,  1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 7};
    tbl[1] = '{7,  1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 7};
    tbl[2] = '{0,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[3] = '{65, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{3,  1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[5] = '{64, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64};
    tbl[6] = '{1,  1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[7] = '{2,  1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 32'(in_ready), 32'd1);
    armed = 1'b1;

    for (int v = 0; v < 8; v++) begin
      we0  = we_cnt;
      low0 = low_cnt;
      run_frame(tbl[v].cnt, tbl[v].flip, tbl[v].garb,
                tbl[v].allsync, tbl[v].fixed0, 1'b0);
      check_frame($sformatf("vec%0d", v), tbl[v].e_done,
                  tbl[v].e_err, tbl[v].e_we, we0, low0);
      if (v == 0)
        chk("vec0_word0", dut_mem[0], 32'h010A4820);
    end

    for (int r = 0; r < 8; r++) begin
      pick = $urandom_range(0, 3);
      if (pick == 0) c = ($urandom_range(0, 1) == 0) ? 0 : 65 + $urandom_range(0, 190);
      else c = $urandom_range(1, 64);
      fl     = $urandom_range(0, 2) == 0;
      ok_cnt = c >= 1 && c <= DEPTH;
      we0    = we_cnt;
      low0   = low_cnt;
      run_frame(c, fl, $urandom_range(0, 3), 1'b0, 1'b0, 1'b1);
      check_frame($sformatf("rnd%0d", r), ok_cnt && !fl,
                  !(ok_cnt && !fl), ok_cnt ? c : 0, we0, low0);
    end

    // Abort a 4-word frame after two words have been written.
    cur_lim = 4;
    w0 = $urandom;
    w1 = $urandom;
    send_byte(8'hA5);
    send_byte(8'h04);
    for (int k = 0; k < 4; k++) send_byte(w0[31-8*k -: 8]);
    for (int k = 0; k < 4; k++) send_byte(w1[31-8*k -: 8]);
    model_mem[0] = w0;
    model_mem[1] = w1;
    idle(3);
    chk("abort_words_before", 32'(words_loaded), 32'd2);
    armed = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_words", 32'(words_loaded), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_err", 32'(load_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    we0  = we_cnt;
    low0 = low_cnt;
    run_frame(1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_frame("after_abort", 1'b1, 1'b0, 1, we0, low0);

    chk("handshake_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 6, meaning instruction-memory word-address width (depth 2^ADDR_W = 64 words).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, meaning frame start marker.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader accepts in_data when in_valid && in_ready.
REQ-008 im_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-009 im_addr  output  ADDR_W  instruction-memory word address.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 cpu_rst  output  1  active-high reset hold for the downstream mips_processor.
REQ-012 load_done  output  1  frame loaded and checksum matched.
REQ-013 load_err  output  1  last frame rejected.
REQ-014 words_loaded  output  ADDR_W+1  count of words written in the current frame.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, COUNT (words, 1..2^ADDR_W), COUNT*4 data bytes big-endian (first byte = instr[31:24]), CHK = XOR of all data bytes.
REQ-016 FSM states SHALL be IDLE, COUNT, DATA, CHECK, DONE, ERROR.
REQ-017 IDLE: byte == SYNC_BYTE -> COUNT; any other byte discarded, stay IDLE.
REQ-018 COUNT: byte 0 or byte > 2^ADDR_W -> ERROR; else latch count, clear words_loaded, byte index and checksum -> DATA.
REQ-019 DATA: each accepted byte shifts into a 32-bit assembly register and XORs into the checksum; byte index wraps 3 -> 0.
REQ-020 On the 4th byte of a word, im_we SHALL pulse the next cycle with im_addr = words_loaded and im_wdata = assembled word; words_loaded increments in that same cycle.
REQ-021 in_ready SHALL be 0 in the cycle im_we is 1 (one-cycle backpressure per word) and 1 otherwise, except during reset.
REQ-022 After the write for word COUNT-1 -> CHECK.
REQ-023 CHECK: byte == checksum -> DONE; mismatch -> ERROR.
REQ-024 DONE: load_done = 1, cpu_rst = 0; SYNC_BYTE -> COUNT with load_done cleared and cpu_rst = 1 in the following cycle; other bytes ignored.
REQ-025 ERROR: load_err = 1, cpu_rst = 1; SYNC_BYTE -> COUNT with load_err cleared; other bytes ignored.
REQ-026 cpu_rst SHALL be 1 in every state except DONE.
REQ-027 im_we SHALL never assert outside DATA-completion cycles; im_addr SHALL never exceed COUNT-1.
REQ-028 in_valid with in_ready = 0 SHALL not consume the byte; the source holds in_data.
REQ-029 A SYNC_BYTE value inside DATA or CHECK SHALL be treated as data, not as a restart.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, im_we 0, im_addr 0, im_wdata 0, in_ready 0, cpu_rst 1, load_done 0, load_err 0, words_loaded 0, checksum 0.
REQ-031 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-032 Reset mid-frame SHALL discard the partial frame; already-written memory words are not cleared.

Structure
REQ-033 State encoding, SYNC_BYTE and default ADDR_W SHALL live in a shared package imem_loader_pkg.
REQ-034 One sub-module, byte_assembler (shift register, byte index and XOR checksum), SHALL be instantiated; the FSM stays in imem_loader.

Verification
REQ-035 Frame A5,07, 7 words (first 01 0A 48 20 = add $t1,$t0,$t2), correct CHK -> 7 im_we pulses, addresses 0..6, im_wdata[0]=32'h010A4820, load_done=1, cpu_rst=0.
REQ-036 Same frame with CHK XOR 8'h01 -> load_err=1, cpu_rst stays 1, load_done=0.
REQ-037 COUNT=0 and COUNT=65 -> ERROR immediately, no im_we.
REQ-038 Garbage bytes 00,FF,12 before A5 -> ignored; frame loads normally.
REQ-039 rst low after 2 of 4 words -> state IDLE, cpu_rst=1; next full 1-word frame writes address 0.
REQ-040 in_valid held high continuously -> in_ready low exactly one cycle per word; no byte lost or duplicated (compare memory to the sent image).
